// File: rtl/reg_dump_pkg.sv
// Shared types for the register-file dump sequencer.
package reg_dump_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SEND0 = 3'd2,
        SEND1 = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/reg_dump_ctrl.sv
// Register-file dump sequencer: fetches register pairs over both read ports
// and streams them one word per beat on a valid/ready interface.
module reg_dump_ctrl
    import reg_dump_pkg::*;
#(
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned NumRegs    = 32,
    parameter int unsigned IndexWidth = $clog2(NumRegs)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [IndexWidth-1:0] readAddr1,
    output logic [IndexWidth-1:0] readAddr2,
    input  logic [DataWidth-1:0]  readData1,
    input  logic [DataWidth-1:0]  readData2,
    output logic                  wr_block,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DataWidth-1:0]  out_data,
    output logic [IndexWidth-1:0] out_idx,
    output logic                  out_last,
    output logic                  done
);

    localparam logic [IndexWidth-1:0] LastIdx = IndexWidth'(NumRegs - 1);

    state_e                state, state_nxt;
    logic [IndexWidth-1:0] base, base_nxt;       // 2p: even index of current pair
    logic [IndexWidth-1:0] odd_idx;
    logic [DataWidth-1:0]  buf1, buf1_nxt;       // out_data doubles as the even-word capture
    logic [IndexWidth-1:0] addr1_nxt, addr2_nxt;
    logic [DataWidth-1:0]  data_nxt;
    logic [IndexWidth-1:0] idx_nxt;
    logic                  last_nxt, valid_nxt, busy_nxt, done_nxt;

    assign odd_idx  = base | IndexWidth'(1);
    assign wr_block = busy;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            base      <= '0;
            buf1      <= '0;
            readAddr1 <= '0;
            readAddr2 <= IndexWidth'(1);
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            base      <= base_nxt;
            buf1      <= buf1_nxt;
            readAddr1 <= addr1_nxt;
            readAddr2 <= addr2_nxt;
            out_data  <= data_nxt;
            out_idx   <= idx_nxt;
            out_last  <= last_nxt;
            out_valid <= valid_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    // Next state; beat fields only change on a handshake or a fresh fetch
    always_comb begin
        state_nxt = state;
        base_nxt  = base;
        buf1_nxt  = buf1;
        addr1_nxt = readAddr1;
        addr2_nxt = readAddr2;
        data_nxt  = out_data;
        idx_nxt   = out_idx;
        last_nxt  = out_last;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FETCH;
                    base_nxt  = '0;
                    addr1_nxt = '0;
                    addr2_nxt = IndexWidth'(1);
                end
            end
            FETCH: begin
                data_nxt  = readData1;
                buf1_nxt  = readData2;
                idx_nxt   = base;
                last_nxt  = 1'b0;
                state_nxt = SEND0;
            end
            SEND0: begin
                if (out_ready) begin
                    data_nxt  = buf1;
                    idx_nxt   = odd_idx;
                    last_nxt  = (odd_idx == LastIdx);
                    state_nxt = SEND1;
                end
            end
            SEND1: begin
                if (out_ready) begin
                    last_nxt = 1'b0;
                    if (odd_idx == LastIdx) begin
                        state_nxt = DONE;
                    end else begin
                        base_nxt  = base + IndexWidth'(2);
                        addr1_nxt = base + IndexWidth'(2);
                        addr2_nxt = base + IndexWidth'(3);
                        state_nxt = FETCH;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        valid_nxt = (state_nxt == SEND0) || (state_nxt == SEND1);
        busy_nxt  = (state_nxt != IDLE);
        done_nxt  = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Directed bench for reg_dump_ctrl: 32-entry dumps against a gated register
// file model, plus a cycle-exact vector table on a 2-entry instance.
module tb_reg_dump_ctrl;

    localparam logic [63:0] Base = 64'hA000_0000_0000_0000;
    localparam logic [63:0] S0   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] S1   = 64'hFEDC_BA98_7654_3210;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic [4:0]  readAddr1, readAddr2, out_idx;
    logic [63:0] readData1, readData2, out_data;
    logic        wr_block, busy, out_valid, out_last, done;

    logic        s_start = 1'b0;
    logic        s_rdy = 1'b0;
    logic [0:0]  s_addr1, s_addr2, s_idx;
    logic [63:0] s_rd1, s_rd2, s_data;
    logic        s_wrb, s_busy, s_valid, s_last, s_done;

    logic [63:0] rf [32];
    logic [63:0] exp_rf [32];
    logic        load_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    int          wr_req_cnt = 0;
    int          wr_ack_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    reg_dump_ctrl #(.DataWidth(64), .NumRegs(32)) dut (
        .clk(clk), .rst(rst), .start(start),
        .readAddr1(readAddr1), .readAddr2(readAddr2),
        .readData1(readData1), .readData2(readData2),
        .wr_block(wr_block), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx),
        .out_last(out_last), .done(done)
    );

    reg_dump_ctrl #(.DataWidth(64), .NumRegs(2)) dut_small (
        .clk(clk), .rst(rst), .start(s_start),
        .readAddr1(s_addr1), .readAddr2(s_addr2),
        .readData1(s_rd1), .readData2(s_rd2),
        .wr_block(s_wrb), .busy(s_busy),
        .out_valid(s_valid), .out_ready(s_rdy),
        .out_data(s_data), .out_idx(s_idx),
        .out_last(s_last), .done(s_done)
    );

    assign readData1 = rf[readAddr1];
    assign readData2 = rf[readAddr2];
    assign s_rd1 = (s_addr1 == 1'b1) ? S1 : S0;
    assign s_rd2 = (s_addr2 == 1'b1) ? S1 : S0;

    // Register file with the write port gated by wr_block
    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 32; i++) rf[i] <= Base + 64'(i);
        end else if (wr_req_cnt != wr_ack_cnt && !wr_block) begin
            rf[wr_addr] <= wr_data;
            wr_ack_cnt  <= wr_ack_cnt + 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    // One full dump on the 32-entry instance.
    // mode 0: ready held high; mode 1: ready pattern 1,0,0,1.
    task automatic run_dump(input int mode, input int rst_at, input int start_at, input int wr_at);
        int          k, nbeats, ndone, last_hs, done_k, first_v;
        logic        pv, pr, pl, fin, aborted;
        logic [63:0] pd;
        logic [4:0]  pi;
        logic [3:0]  pat;
        pat = 4'b1001;
        k = 0; nbeats = 0; ndone = 0; last_hs = -1; done_k = -1; first_v = -1;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; pi = '0;
        fin = 1'b0; aborted = 1'b0;
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b0;
        while (!fin) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            if (k > 400) begin
                chk("dump_timeout", 64'(k), 64'(0));
                fin = 1'b1;
            end else begin
                if (pv && !pr) begin
                    chk("stall_valid", 64'(out_valid), 64'(1));
                    chk("stall_data", out_data, pd);
                    chk("stall_idx", 64'(out_idx), 64'(pi));
                    chk("stall_last", 64'(out_last), 64'(pl));
                end
                if (k == 1) begin
                    chk("fetch_busy", 64'(busy), 64'(1));
                    chk("fetch_wr_block", 64'(wr_block), 64'(1));
                    chk("fetch_valid", 64'(out_valid), 64'(0));
                end
                if (mode == 0 && k <= 48 && (k % 3) == 1) begin
                    chk("fetch_addr1", 64'(readAddr1), 64'(2 * ((k - 1) / 3)));
                    chk("fetch_addr2", 64'(readAddr2), 64'(2 * ((k - 1) / 3) + 1));
                end
                out_ready = (mode == 0) ? 1'b1 : pat[k % 4];
                if (out_valid && first_v < 0) first_v = k;
                if (done) begin
                    ndone++;
                    done_k = k;
                    chk("done_wr_block", 64'(wr_block), 64'(1));
                end
                if (out_valid && rst_at >= 0 && out_idx == 5'(rst_at)) begin
                    rst = 1'b0;
                    aborted = 1'b1;
                    fin = 1'b1;
                end else if (out_valid && out_ready) begin
                    chk("beat_idx", 64'(out_idx), 64'(nbeats));
                    chk("beat_data", out_data, exp_rf[nbeats]);
                    chk("beat_last", 64'(out_last), 64'(nbeats == 31));
                    last_hs = k;
                    if (nbeats == start_at) start = 1'b1;
                    if (nbeats == wr_at) begin
                        wr_addr = 5'd20;
                        wr_data = 64'hDEAD;
                        wr_req_cnt++;
                    end
                    nbeats++;
                end else if (k > 1 && !busy) begin
                    fin = 1'b1;
                end
                pv = out_valid; pr = out_ready; pd = out_data; pi = out_idx; pl = out_last;
            end
        end
        out_ready = 1'b0;
        if (aborted) begin
            @(negedge clk);
            chk("rst_valid", 64'(out_valid), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_wr_block", 64'(wr_block), 64'(0));
            rst = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                chk("rst_no_done", 64'(done), 64'(0));
            end
        end else begin
            chk("beat_count", 64'(nbeats), 64'(32));
            chk("done_count", 64'(ndone), 64'(1));
            if (mode == 0 && start_at < 0) begin
                chk("first_valid_cycle", 64'(first_v), 64'(2));
                chk("last_hs_cycle", 64'(last_hs), 64'(48));
                chk("done_cycle", 64'(done_k), 64'(49));
            end
            repeat (2) @(negedge clk);
            chk("idle_after_dump", 64'(busy), 64'(0));
        end
    endtask

    typedef struct {
        logic        start;
        logic        rdy;
        logic        valid;
        logic        idx;
        logic        last;
        logic        done;
        logic        busy;
        logic [63:0] data;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        // inputs applied before an edge, outputs expected after it
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, S0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, S0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, S1};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, S1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0};
        for (int i = 0; i < 32; i++) exp_rf[i] = Base + 64'(i);

        rst = 1'b0;
        load_en = 1'b1;
        repeat (3) @(negedge clk);
        load_en = 1'b0;
        chk("reset_valid", 64'(out_valid), 64'(0));
        chk("reset_last", 64'(out_last), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_wr_block", 64'(wr_block), 64'(0));
        chk("reset_addr1", 64'(readAddr1), 64'(0));
        chk("reset_addr2", 64'(readAddr2), 64'(1));
        chk("reset_data", out_data, 64'h0);
        chk("reset_idx", 64'(out_idx), 64'(0));
        rst = 1'b1;
        @(negedge clk);

        // Minimum-size instance, cycle by cycle
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            s_start = vecs[i].start;
            s_rdy   = vecs[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), 64'(s_valid), 64'(vecs[i].valid));
            chk($sformatf("v%0d_done", i), 64'(s_done), 64'(vecs[i].done));
            chk($sformatf("v%0d_busy", i), 64'(s_busy), 64'(vecs[i].busy));
            chk($sformatf("v%0d_wr_block", i), 64'(s_wrb), 64'(vecs[i].busy));
            chk($sformatf("v%0d_last", i), 64'(s_last), 64'(vecs[i].last));
            if (vecs[i].valid) begin
                chk($sformatf("v%0d_idx", i), 64'(s_idx), 64'(vecs[i].idx));
                chk($sformatf("v%0d_data", i), s_data, vecs[i].data);
            end
        end
        @(negedge clk);
        s_start = 1'b0;
        s_rdy   = 1'b1;

        run_dump(0, -1, -1, -1);   // basic
        run_dump(1, -1, -1, -1);   // backpressure
        run_dump(0, 9, -1, -1);    // reset mid-dump
        run_dump(0, -1, -1, -1);   // full dump after abort
        run_dump(0, -1, 5, -1);    // start while busy

        run_dump(0, -1, -1, 3);    // blocked write during dump
        repeat (3) @(negedge clk);
        chk("write_released", 64'(wr_ack_cnt), 64'(wr_req_cnt));
        exp_rf[20] = 64'hDEAD;
        run_dump(0, -1, -1, -1);   // write visible in next dump

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
